// File: rtl/per2axi_req_channel_buf.sv
`default_nettype none
// ============================================================================
// Module   : per2axi_req_channel_buf
// Purpose  : Buffered request channel of the peripheral-to-AXI bridge.
//            Peripheral requests are queued in a DEPTH-entry FIFO and then
//            issued as single-beat AXI4 AR or AW+W transactions. AW and W
//            handshake independently. Write data is steered onto the 32-bit
//            lane selected by the address. In-flight transactions are capped
//            per direction. The response channel is told about every issued
//            read and write.
// Ports    : clk_i / rst_ni          clock, synchronous active-low reset
//            per_slave_*             peripheral request in, grant out
//            axi_axuser_i            per-core AXI user values, packed by core
//            axi_master_aw/ar/w_*    AXI write address, read address and
//                                    write data channels
//            rd_done_i / wr_done_i   a read / write response was retired
//            trans_*_o, wr_issued_o  issued read info, write-issued pulse
// Revision : 1.0 - initial release
// ============================================================================
module per2axi_req_channel_buf #(
  parameter int NB_CORES       = 4,
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int DEPTH          = 2,
  parameter int MAX_OUTST      = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               per_slave_req_i,
  input  logic [PER_ADDR_WIDTH-1:0]          per_slave_add_i,
  input  logic                               per_slave_we_i,
  input  logic [5:0]                         per_slave_atop_i,
  input  logic [31:0]                        per_slave_wdata_i,
  input  logic [3:0]                         per_slave_be_i,
  input  logic [PER_ID_WIDTH-1:0]            per_slave_id_i,
  output logic                               per_slave_gnt_o,
  input  logic [NB_CORES*AXI_USER_WIDTH-1:0] axi_axuser_i,
  output logic                               axi_master_aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_master_aw_addr_o,
  output logic [2:0]                         axi_master_aw_size_o,
  output logic [1:0]                         axi_master_aw_burst_o,
  output logic                               axi_master_aw_lock_o,
  output logic [AXI_ID_WIDTH-1:0]            axi_master_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]          axi_master_aw_user_o,
  output logic [5:0]                         axi_master_aw_atop_o,
  input  logic                               axi_master_aw_ready_i,
  output logic                               axi_master_ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]          axi_master_ar_addr_o,
  output logic [2:0]                         axi_master_ar_size_o,
  output logic [1:0]                         axi_master_ar_burst_o,
  output logic                               axi_master_ar_lock_o,
  output logic [AXI_ID_WIDTH-1:0]            axi_master_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]          axi_master_ar_user_o,
  input  logic                               axi_master_ar_ready_i,
  output logic                               axi_master_w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]          axi_master_w_data_o,
  output logic [AXI_STRB_WIDTH-1:0]          axi_master_w_strb_o,
  output logic                               axi_master_w_last_o,
  input  logic                               axi_master_w_ready_i,
  input  logic                               rd_done_i,
  input  logic                               wr_done_i,
  output logic                               trans_req_o,
  output logic [AXI_ID_WIDTH-1:0]            trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]          trans_add_o,
  output logic                               wr_issued_o
);

  // Cluster-wide atomic opcode encoding for load-reserved / store-conditional
  localparam logic [5:0] AMO_LR = 6'b100010;
  localparam logic [5:0] AMO_SC = 6'b100011;

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int NLANES = AXI_DATA_WIDTH / 32;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  // FIFO storage (payload needs no reset; outputs are gated by valid)
  logic [PER_ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic                      we_q    [DEPTH];
  logic [5:0]                atop_q  [DEPTH];
  logic [31:0]               wdata_q [DEPTH];
  logic [3:0]                be_q    [DEPTH];
  logic [AXI_ID_WIDTH-1:0]   id_q    [DEPTH];
  logic [2:0]                size_q  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              aw_sent_q, aw_sent_d, w_sent_q, w_sent_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic                      full, head_valid, head_rd, head_wr;
  logic                      push, pop, wr_pop;
  logic                      ar_valid, aw_valid, w_valid;
  logic                      ar_hs, aw_hs, w_hs, rd_dec, wr_dec;
  logic                      rd_room, wr_room;
  logic [AXI_ID_WIDTH-1:0]   in_id_bin;
  logic [2:0]                in_size;
  logic [PER_ADDR_WIDTH-1:0] h_addr;
  logic                      h_we;
  logic [5:0]                h_atop;
  logic [31:0]               h_wdata;
  logic [3:0]                h_be;
  logic [AXI_ID_WIDTH-1:0]   h_id;
  logic [2:0]                h_size;
  logic [AXI_USER_WIDTH-1:0] h_user;
  logic [LANE_W-1:0]         h_lane;
  logic [AXI_DATA_WIDTH-1:0] h_wdata_lane;
  logic [AXI_STRB_WIDTH-1:0] h_strb_lane;

  // ---------------------------------------------------------------- request
  // Highest set bit wins so that a malformed multi-hot ID is still decoded
  always_comb begin
    in_id_bin = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++) begin
      if (per_slave_id_i[i]) in_id_bin = AXI_ID_WIDTH'(i);
    end
  end

  always_comb begin
    case (per_slave_be_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: in_size = 3'd0;
      4'b0011, 4'b0110, 4'b1100:          in_size = 3'd1;
      default:                            in_size = 3'd2;
    endcase
  end

  assign full            = (fill_q == FILL_W'(DEPTH));
  assign head_valid      = (fill_q != '0);
  assign per_slave_gnt_o = ~full;
  assign push            = per_slave_req_i & ~full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= per_slave_add_i;
      we_q[wr_ptr_q]    <= per_slave_we_i;
      atop_q[wr_ptr_q]  <= per_slave_atop_i;
      wdata_q[wr_ptr_q] <= per_slave_wdata_i;
      be_q[wr_ptr_q]    <= per_slave_be_i;
      id_q[wr_ptr_q]    <= in_id_bin;
      size_q[wr_ptr_q]  <= in_size;
    end
  end

  // ------------------------------------------------------------------- head
  assign h_addr  = addr_q[rd_ptr_q];
  assign h_we    = we_q[rd_ptr_q];
  assign h_atop  = atop_q[rd_ptr_q];
  assign h_wdata = wdata_q[rd_ptr_q];
  assign h_be    = be_q[rd_ptr_q];
  assign h_id    = id_q[rd_ptr_q];
  assign h_size  = size_q[rd_ptr_q];

  always_comb begin
    h_user = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      if (int'(h_id) == c) h_user = axi_axuser_i[c*AXI_USER_WIDTH +: AXI_USER_WIDTH];
    end
  end

  // Address bits above the 32-bit word select the lane of a wide data bus
  if (NLANES > 1) begin : g_lane_sel
    assign h_lane = h_addr[LANE_W+1:2];
  end else begin : g_lane_single
    assign h_lane = '0;
  end

  assign h_wdata_lane = AXI_DATA_WIDTH'(h_wdata) << {h_lane, 5'b0};
  assign h_strb_lane  = AXI_STRB_WIDTH'(h_be) << {h_lane, 2'b0};

  // --------------------------------------------------------------- channels
  // Counters only grow through this channel's own handshakes, so a valid
  // raised under the limit cannot be withdrawn before its handshake.
  assign rd_room  = (rd_cnt_q < CNT_W'(MAX_OUTST));
  assign wr_room  = (wr_cnt_q < CNT_W'(MAX_OUTST));
  assign head_rd  = head_valid & h_we;
  assign head_wr  = head_valid & ~h_we;
  assign ar_valid = head_rd & rd_room;
  assign aw_valid = head_wr & ~aw_sent_q & wr_room;
  assign w_valid  = head_wr & ~w_sent_q & wr_room;
  assign ar_hs    = ar_valid & axi_master_ar_ready_i;
  assign aw_hs    = aw_valid & axi_master_aw_ready_i;
  assign w_hs     = w_valid & axi_master_w_ready_i;
  assign wr_pop   = head_wr & (aw_sent_q | aw_hs) & (w_sent_q | w_hs);
  assign pop      = ar_hs | wr_pop;

  assign axi_master_ar_valid_o = ar_valid;
  assign axi_master_ar_addr_o  = ar_valid ? AXI_ADDR_WIDTH'(h_addr) : '0;
  assign axi_master_ar_size_o  = ar_valid ? h_size : 3'd0;
  assign axi_master_ar_burst_o = 2'b00;
  assign axi_master_ar_lock_o  = ar_valid & (h_atop == AMO_LR);
  assign axi_master_ar_id_o    = ar_valid ? h_id : '0;
  assign axi_master_ar_user_o  = ar_valid ? h_user : '0;

  assign axi_master_aw_valid_o = aw_valid;
  assign axi_master_aw_addr_o  = aw_valid ? AXI_ADDR_WIDTH'(h_addr) : '0;
  assign axi_master_aw_size_o  = aw_valid ? h_size : 3'd0;
  assign axi_master_aw_burst_o = 2'b00;
  assign axi_master_aw_lock_o  = aw_valid & (h_atop == AMO_SC);
  assign axi_master_aw_id_o    = aw_valid ? h_id : '0;
  assign axi_master_aw_user_o  = aw_valid ? h_user : '0;
  assign axi_master_aw_atop_o  = (aw_valid && h_atop != AMO_SC) ? h_atop : 6'd0;

  assign axi_master_w_valid_o  = w_valid;
  assign axi_master_w_data_o   = w_valid ? h_wdata_lane : '0;
  assign axi_master_w_strb_o   = w_valid ? h_strb_lane : '0;
  assign axi_master_w_last_o   = 1'b1;

  assign trans_req_o = ar_hs;
  assign trans_id_o  = ar_hs ? h_id : '0;
  assign trans_add_o = ar_hs ? AXI_ADDR_WIDTH'(h_addr) : '0;
  assign wr_issued_o = wr_pop;

  // ------------------------------------------------------------- next state
  assign rd_dec = rd_done_i & (rd_cnt_q != '0);
  assign wr_dec = wr_done_i & (wr_cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    case ({ar_hs, rd_dec})
      2'b10:   rd_cnt_d = rd_cnt_q + 1'b1;
      2'b01:   rd_cnt_d = rd_cnt_q - 1'b1;
      default: rd_cnt_d = rd_cnt_q;
    endcase
    case ({wr_pop, wr_dec})
      2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
      default: wr_cnt_d = wr_cnt_q;
    endcase
    // Sent flags remember a finished half of a write until the other half
    aw_sent_d = wr_pop ? 1'b0 : (aw_sent_q | aw_hs);
    w_sent_d  = wr_pop ? 1'b0 : (w_sent_q | w_hs);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_per2axi_req_channel_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_per2axi_req_channel_buf
// Purpose  : Self-checking bench for per2axi_req_channel_buf. A queue-based
//            reference model predicts every output each cycle; directed
//            scenarios add literal expectations, then random traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_per2axi_req_channel_buf;

  localparam int NB_CORES  = 4;
  localparam int DEPTH     = 2;
  localparam int MAX_OUTST = 4;
  localparam logic [5:0] AMO_LR = 6'b100010;
  localparam logic [5:0] AMO_SC = 6'b100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, we, aw_ready, ar_ready, w_ready, rd_done, wr_done;
  logic [31:0] add, wdata;
  logic [5:0]  atop;
  logic [3:0]  be;
  logic [4:0]  id;
  logic [23:0] axuser;

  logic        gnt, aw_valid, aw_lock, ar_valid, ar_lock, w_valid, w_last, trans_req, wr_issued;
  logic [31:0] aw_addr, ar_addr, trans_add;
  logic [2:0]  aw_size, ar_size, aw_id, ar_id, trans_id;
  logic [1:0]  aw_burst, ar_burst;
  logic [5:0]  aw_user, ar_user, aw_atop;
  logic [63:0] w_data;
  logic [7:0]  w_strb;

  logic         x_gnt, x_aw_valid, x_aw_lock, x_ar_valid, x_ar_lock, x_w_valid, x_w_last, x_trans_req, x_wr_issued;
  logic [31:0]  x_aw_addr, x_ar_addr, x_trans_add;
  logic [2:0]   x_aw_size, x_ar_size, x_aw_id, x_ar_id, x_trans_id;
  logic [1:0]   x_aw_burst, x_ar_burst;
  logic [5:0]   x_aw_user, x_ar_user, x_aw_atop;
  logic [127:0] x_w_data;
  logic [15:0]  x_w_strb;

  per2axi_req_channel_buf dut (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
    .per_slave_atop_i(atop), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_id_i(id), .per_slave_gnt_o(gnt), .axi_axuser_i(axuser),
    .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
    .axi_master_aw_size_o(aw_size), .axi_master_aw_burst_o(aw_burst),
    .axi_master_aw_lock_o(aw_lock), .axi_master_aw_id_o(aw_id),
    .axi_master_aw_user_o(aw_user), .axi_master_aw_atop_o(aw_atop),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_ar_valid_o(ar_valid), .axi_master_ar_addr_o(ar_addr),
    .axi_master_ar_size_o(ar_size), .axi_master_ar_burst_o(ar_burst),
    .axi_master_ar_lock_o(ar_lock), .axi_master_ar_id_o(ar_id),
    .axi_master_ar_user_o(ar_user), .axi_master_ar_ready_i(ar_ready),
    .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
    .axi_master_w_strb_o(w_strb), .axi_master_w_last_o(w_last),
    .axi_master_w_ready_i(w_ready),
    .rd_done_i(rd_done), .wr_done_i(wr_done),
    .trans_req_o(trans_req), .trans_id_o(trans_id), .trans_add_o(trans_add),
    .wr_issued_o(wr_issued)
  );

  // Wide-bus instance fed by the same stimulus, used for lane steering
  per2axi_req_channel_buf #(.AXI_DATA_WIDTH(128)) dut_wide (
    .clk_i(clk), .rst_ni(rst_n),
    .per_slave_req_i(req), .per_slave_add_i(add), .per_slave_we_i(we),
    .per_slave_atop_i(atop), .per_slave_wdata_i(wdata), .per_slave_be_i(be),
    .per_slave_id_i(id), .per_slave_gnt_o(x_gnt), .axi_axuser_i(axuser),
    .axi_master_aw_valid_o(x_aw_valid), .axi_master_aw_addr_o(x_aw_addr),
    .axi_master_aw_size_o(x_aw_size), .axi_master_aw_burst_o(x_aw_burst),
    .axi_master_aw_lock_o(x_aw_lock), .axi_master_aw_id_o(x_aw_id),
    .axi_master_aw_user_o(x_aw_user), .axi_master_aw_atop_o(x_aw_atop),
    .axi_master_aw_ready_i(aw_ready),
    .axi_master_ar_valid_o(x_ar_valid), .axi_master_ar_addr_o(x_ar_addr),
    .axi_master_ar_size_o(x_ar_size), .axi_master_ar_burst_o(x_ar_burst),
    .axi_master_ar_lock_o(x_ar_lock), .axi_master_ar_id_o(x_ar_id),
    .axi_master_ar_user_o(x_ar_user), .axi_master_ar_ready_i(ar_ready),
    .axi_master_w_valid_o(x_w_valid), .axi_master_w_data_o(x_w_data),
    .axi_master_w_strb_o(x_w_strb), .axi_master_w_last_o(x_w_last),
    .axi_master_w_ready_i(w_ready),
    .rd_done_i(rd_done), .wr_done_i(wr_done),
    .trans_req_o(x_trans_req), .trans_id_o(x_trans_id), .trans_add_o(x_trans_add),
    .wr_issued_o(x_wr_issued)
  );

  // ------------------------------------------------------------------ model
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [5:0]  atop;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          idb;
  } req_t;

  req_t q[$];
  int   rd_out, wr_out;
  bit   aw_sent, w_sent, model_ok;
  int   total = 0;
  int   bad = 0;

  function automatic int size_of(logic [3:0] b);
    if ($countones(b) == 1) return 0;
    if (b == 4'b0011 || b == 4'b0110 || b == 4'b1100) return 1;
    return 2;
  endfunction

  function automatic int bin_id(logic [4:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [127:0] lane_data(logic [31:0] a, logic [31:0] d, int dw);
    int lane;
    lane = int'((a >> 2) % (dw / 32));
    return {96'b0, d} << (32 * lane);
  endfunction

  function automatic logic [15:0] lane_strb(logic [31:0] a, logic [3:0] b, int dw);
    int lane;
    lane = int'((a >> 2) % (dw / 32));
    return {12'b0, b} << (4 * lane);
  endfunction

  function automatic logic [5:0] user_of(int i);
    if (i < NB_CORES) return axuser[i*6 +: 6];
    return 6'd0;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model, then advance the model
  task automatic model_step();
    bit e_gnt, e_ar, e_aw, e_w, hs_ar, hs_aw, hs_w, wpop;
    req_t h;
    e_gnt = 0; e_ar = 0; e_aw = 0; e_w = 0; hs_ar = 0; hs_aw = 0; hs_w = 0; wpop = 0;
    if (model_ok) begin
      e_gnt = (q.size() < DEPTH);
      if (q.size() > 0) begin
        h = q[0];
        if (h.we) e_ar = (rd_out < MAX_OUTST);
        else begin
          e_aw = !aw_sent && (wr_out < MAX_OUTST);
          e_w  = !w_sent && (wr_out < MAX_OUTST);
        end
      end
      hs_ar = e_ar && ar_ready;
      hs_aw = e_aw && aw_ready;
      hs_w  = e_w && w_ready;
      wpop  = (q.size() > 0) && !h.we && (aw_sent || hs_aw) && (w_sent || hs_w);
      chk("gnt", gnt, e_gnt);
      chk("ar_valid", ar_valid, e_ar);
      chk("aw_valid", aw_valid, e_aw);
      chk("w_valid", w_valid, e_w);
      chk("wide_w_valid", x_w_valid, e_w);
      chk("trans_req", trans_req, hs_ar);
      chk("wr_issued", wr_issued, wpop);
      if (e_ar) begin
        chk("ar_addr", ar_addr, h.addr);
        chk("ar_id", ar_id, h.idb);
        chk("ar_size", ar_size, size_of(h.be));
        chk("ar_burst", ar_burst, 2'b00);
        chk("ar_lock", ar_lock, h.atop == AMO_LR);
        chk("ar_user", ar_user, user_of(h.idb));
      end
      if (hs_ar) begin
        chk("trans_id", trans_id, h.idb);
        chk("trans_add", trans_add, h.addr);
      end
      if (e_aw) begin
        chk("aw_addr", aw_addr, h.addr);
        chk("aw_id", aw_id, h.idb);
        chk("aw_size", aw_size, size_of(h.be));
        chk("aw_burst", aw_burst, 2'b00);
        chk("aw_lock", aw_lock, h.atop == AMO_SC);
        chk("aw_user", aw_user, user_of(h.idb));
        chk("aw_atop", aw_atop, (h.atop == AMO_SC) ? 6'd0 : h.atop);
      end
      if (e_w) begin
        chk("w_data", w_data, lane_data(h.addr, h.wdata, 64));
        chk("w_strb", w_strb, lane_strb(h.addr, h.be, 64));
        chk("w_last", w_last, 1'b1);
        chk("wide_w_data", x_w_data, lane_data(h.addr, h.wdata, 128));
        chk("wide_w_strb", x_w_strb, lane_strb(h.addr, h.be, 128));
      end
    end
    if (!rst_n) begin
      q.delete();
      rd_out = 0; wr_out = 0; aw_sent = 0; w_sent = 0;
      model_ok = 1;
    end else if (model_ok) begin
      if (hs_ar && !(rd_done && rd_out > 0)) rd_out++;
      else if (!hs_ar && rd_done && rd_out > 0) rd_out--;
      if (wpop && !(wr_done && wr_out > 0)) wr_out++;
      else if (!wpop && wr_done && wr_out > 0) wr_out--;
      if (wpop) begin aw_sent = 0; w_sent = 0; end
      else begin aw_sent = aw_sent || hs_aw; w_sent = w_sent || hs_w; end
      if (hs_ar || wpop) void'(q.pop_front());
      if (req && e_gnt) q.push_back('{add, we, atop, wdata, be, bin_id(id)});
    end
  endtask

  task automatic tick();
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [31:0] a, input logic w, input logic [5:0] at,
                         input logic [31:0] d, input logic [3:0] b, input logic [4:0] i);
    req = 1; add = a; we = w; atop = at; wdata = d; be = b; id = i;
  endtask

  task automatic push_one(input logic [31:0] a, input logic w, input logic [5:0] at,
                          input logic [3:0] b);
    set_req(a, w, at, $urandom, b, 5'b00010);
    tick();
    req = 0;
  endtask

  task automatic drain();
    aw_ready = 1; w_ready = 1; ar_ready = 1; req = 0;
    for (int c = 0; c < 20; c++) begin
      rd_done = (rd_out > 0);
      wr_done = (wr_out > 0);
      tick();
    end
    aw_ready = 0; w_ready = 0; ar_ready = 0; rd_done = 0; wr_done = 0;
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    rst_n = 0; req = 0; we = 0; add = 0; atop = 0; wdata = 0; be = 0; id = 0;
    aw_ready = 0; ar_ready = 0; w_ready = 0; rd_done = 0; wr_done = 0;
    axuser = 24'($urandom);
    model_ok = 0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1;
    #1;
    chk("reset_gnt", gnt, 1'b1);
    chk("reset_ar_valid", ar_valid, 1'b0);
    chk("reset_aw_valid", aw_valid, 1'b0);
    chk("reset_w_valid", w_valid, 1'b0);

    // First write, issued the cycle after acceptance
    set_req(32'h104, 1'b0, 6'd0, 32'hDEADBEEF, 4'b1111, 5'b00100);
    chk("same_cycle_aw_valid", aw_valid, 1'b0);
    tick();
    req = 0; aw_ready = 1;
    #1;
    chk("w1_aw_valid", aw_valid, 1'b1);
    chk("w1_w_valid", w_valid, 1'b1);
    chk("w1_aw_addr", aw_addr, 32'h104);
    chk("w1_aw_id", aw_id, 3'd2);
    chk("w1_aw_size", aw_size, 3'd2);
    chk("w1_w_data", w_data, 64'hDEADBEEF_00000000);
    chk("w1_w_strb", w_strb, 8'hF0);
    chk("w1_w_last", w_last, 1'b1);
    chk("w1_wide_strb", x_w_strb, 16'h00F0);
    tick();
    aw_ready = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("w1_aw_dropped", aw_valid, 1'b0);
      chk("w1_w_held", w_valid, 1'b1);
      chk("w1_w_data_held", w_data, 64'hDEADBEEF_00000000);
      chk("w1_no_issue", wr_issued, 1'b0);
      tick();
    end
    w_ready = 1;
    #1;
    chk("w1_issued", wr_issued, 1'b1);
    tick();
    w_ready = 0;
    #1;
    chk("w1_issued_once", wr_issued, 1'b0);
    chk("w1_popped", w_valid, 1'b0);

    // Three back-to-back reads into a two-entry FIFO
    set_req(32'h200, 1'b1, 6'd0, 32'd0, 4'b1111, 5'b00001);
    #1; chk("rd_gnt0", gnt, 1'b1); tick();
    set_req(32'h204, 1'b1, 6'd0, 32'd0, 4'b1111, 5'b00010);
    #1; chk("rd_gnt1", gnt, 1'b1); tick();
    set_req(32'h208, 1'b1, 6'd0, 32'd0, 4'b1111, 5'b01000);
    #1; chk("rd_gnt2", gnt, 1'b0); tick();
    req = 0; ar_ready = 1;
    #1;
    chk("rd0_trans", trans_req, 1'b1);
    chk("rd0_id", trans_id, 3'd0);
    chk("rd0_add", trans_add, 32'h200);
    tick();
    #1;
    chk("rd1_trans", trans_req, 1'b1);
    chk("rd1_id", trans_id, 3'd1);
    chk("rd1_add", trans_add, 32'h204);
    tick();

    // Outstanding read cap (two already in flight)
    push_one(32'h300, 1'b1, 6'd0, 4'b1111);
    push_one(32'h304, 1'b1, 6'd0, 4'b1111);
    push_one(32'h308, 1'b1, 6'd0, 4'b1111);
    #1; chk("cap_blocked", ar_valid, 1'b0); tick();
    rd_done = 1;
    #1; chk("cap_blocked_done", ar_valid, 1'b0); tick();
    rd_done = 0;
    #1; chk("cap_released", ar_valid, 1'b1); tick();
    push_one(32'h30C, 1'b1, 6'd0, 4'b1111);
    rd_done = 1;
    #1; chk("cap_d_blocked", ar_valid, 1'b0); tick();
    #1; chk("cap_d_issue_with_done", ar_valid, 1'b1); tick();
    rd_done = 0;
    push_one(32'h310, 1'b1, 6'd0, 4'b1111);
    #1; chk("cap_e_issue", ar_valid, 1'b1); tick();
    push_one(32'h314, 1'b1, 6'd0, 4'b1111);
    #1; chk("cap_f_blocked", ar_valid, 1'b0);
    drain();

    // Atomics, sizes and wide lane steering
    push_one(32'h10, 1'b0, AMO_SC, 4'b1111);
    #1; chk("sc_aw_lock", aw_lock, 1'b1); chk("sc_aw_atop", aw_atop, 6'd0);
    aw_ready = 1; w_ready = 1; tick(); aw_ready = 0; w_ready = 0;
    push_one(32'h20, 1'b1, AMO_LR, 4'b1111);
    #1; chk("lr_ar_lock", ar_lock, 1'b1);
    ar_ready = 1; tick(); ar_ready = 0;
    push_one(32'h0C, 1'b0, 6'd0, 4'b1111);
    #1; chk("wide_strb_c", x_w_strb, 16'hF000); chk("strb_c", w_strb, 8'hF0);
    aw_ready = 1; w_ready = 1; tick(); aw_ready = 0; w_ready = 0;
    push_one(32'h40, 1'b0, 6'd0, 4'b0110);
    #1; chk("size_0110", aw_size, 3'd1);
    aw_ready = 1; w_ready = 1; tick(); aw_ready = 0; w_ready = 0;
    push_one(32'h44, 1'b0, 6'h21, 4'b1010);
    #1; chk("size_1010", aw_size, 3'd2); chk("atop_pass", aw_atop, 6'h21);
    drain();

    // Reset while reads are pending
    push_one(32'h500, 1'b1, 6'd0, 4'b1111);
    push_one(32'h504, 1'b1, 6'd0, 4'b1111);
    #1; chk("pre_rst_ar_valid", ar_valid, 1'b1); chk("pre_rst_gnt", gnt, 1'b0);
    rst_n = 0; tick(); rst_n = 1;
    #1;
    chk("post_rst_ar_valid", ar_valid, 1'b0);
    chk("post_rst_aw_valid", aw_valid, 1'b0);
    chk("post_rst_gnt", gnt, 1'b1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      req   = ($urandom_range(0, 1) == 1);
      we    = ($urandom_range(0, 1) == 1);
      add   = $urandom;
      wdata = $urandom;
      be    = 4'($urandom);
      case ($urandom_range(0, 7))
        0: atop = AMO_LR;
        1: atop = AMO_SC;
        2: atop = 6'($urandom);
        default: atop = 6'd0;
      endcase
      id       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
      ar_ready = ($urandom_range(0, 3) != 0);
      aw_ready = ($urandom_range(0, 2) != 0);
      w_ready  = ($urandom_range(0, 2) != 0);
      rd_done  = ($urandom_range(0, 3) == 0);
      wr_done  = ($urandom_range(0, 3) == 0);
      rst_n    = !(c % 997 == 996);
      tick();
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
